// File: rtl/adc_trig_capture_if.sv
// adc_trig_capture_if -- signal bundle between the trigger/capture block and
// its environment (ADC sample stream, capture control, readout port).
//
// Signals (directions seen from the capture block, i.e. the slave modport):
//   ad_data_i    in  10          ADC sample, one per clock
//   arm_i        in  1           pulse: start (or restart) a capture
//   trig_level_i in  10          trigger threshold
//   trig_edge_i  in  1           0 = rising, 1 = falling
//   pretrig_i    in  DEPTH_LOG2  requested pre-trigger sample count
//   force_i      in  1           force a trigger while waiting
//   rd_en_i      in  1           readout request, one sample per cycle
//   rd_data_o    out 10          readout sample
//   rd_valid_o   out 1           rd_data_o valid this cycle
//   busy_o       out 1           capture in progress
//   done_o       out 1           buffer holds a completed capture
interface adc_trig_capture_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic [9:0]            ad_data_i;
  logic                  arm_i;
  logic [9:0]            trig_level_i;
  logic                  trig_edge_i;
  logic [DEPTH_LOG2-1:0] pretrig_i;
  logic                  force_i;
  logic                  rd_en_i;
  logic [9:0]            rd_data_o;
  logic                  rd_valid_o;
  logic                  busy_o;
  logic                  done_o;

  // Environment side: drives samples and control, observes readout/status.
  modport master (
    output ad_data_i, arm_i, trig_level_i, trig_edge_i, pretrig_i, force_i, rd_en_i,
    input  rd_data_o, rd_valid_o, busy_o, done_o
  );

  // Capture block side.
  modport slave (
    input  ad_data_i, arm_i, trig_level_i, trig_edge_i, pretrig_i, force_i, rd_en_i,
    output rd_data_o, rd_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/adc_trig_capture.sv
// adc_trig_capture -- triggered ADC capture into a circular buffer with
// pre-trigger history and sequential readout.
//
// Ports:
//   clk     in  sample clock (same clock as the ADC driver)
//   rst_n   in  asynchronous active-low reset
//   cap_if  adc_trig_capture_if.slave (samples, control, readout, status)
//
// Parameters:
//   DEPTH_LOG2  log2 of buffer depth (default 10 -> 1024 samples)
//   HYST        trigger hysteresis in LSBs (only with TRIG_HYST_EN)
//
// Build option: define TRIG_HYST_EN to require the signal to have gone past
// the threshold by HYST LSBs (on the far side) since arm or since the last
// crossing before a crossing counts as a trigger.
//
// Flow: IDLE -arm-> PRE (P samples) -> WAIT (until trigger/force) -> POST
// (until DEPTH-P samples including the trigger sample) -> DONE (DEPTH reads)
// -> IDLE. An arm in any state restarts the capture.
module adc_trig_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int HYST       = 8
) (
  input logic               clk,
  input logic               rst_n,
  adc_trig_capture_if.slave cap_if
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [AW-1:0] PRE_MAX  = AW'(DEPTH - 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   pre_q, pre_d;
  logic [9:0]      level_q, level_d;
  logic            edge_q, edge_d;
  logic [9:0]      prev_q, prev_d;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [9:0]      rd_data_q;
  logic            rd_valid_q;
  logic            busy_q;
  logic            done_q;

  logic            wr_en_s;
  logic            rd_acc_s;
  logic [AW-1:0]   pre_clamp_s;
  logic [CW-1:0]   pre_last_s;
  logic [CW-1:0]   post_last_s;
  logic            rise_s;
  logic            fall_s;
  logic            cross_s;
  logic            trig_s;

  logic [9:0]      mem [DEPTH];

  // Crossing detection against the previous written sample.
  always_comb begin
    rise_s  = (prev_q < level_q) && (cap_if.ad_data_i >= level_q);
    fall_s  = (prev_q > level_q) && (cap_if.ad_data_i <= level_q);
    cross_s = edge_q ? fall_s : rise_s;
  end

`ifdef TRIG_HYST_EN
  localparam logic [10:0] HYST_W   = 11'(HYST);
  localparam logic [10:0] CODE_MAX = 11'd1023;

  logic        armed_q, armed_d;
  logic [10:0] hyst_lo_s;
  logic [10:0] hyst_hi_s;
  logic        qualify_s;

  // Hysteresis thresholds, saturating at the ends of the code range.
  always_comb begin
    if ({1'b0, level_q} >= HYST_W) begin
      hyst_lo_s = {1'b0, level_q} - HYST_W;
    end else begin
      hyst_lo_s = 11'd0;
    end
    if (({1'b0, level_q} + HYST_W) > CODE_MAX) begin
      hyst_hi_s = CODE_MAX;
    end else begin
      hyst_hi_s = {1'b0, level_q} + HYST_W;
    end
    qualify_s = edge_q ? ({1'b0, cap_if.ad_data_i} >= hyst_hi_s)
                       : ({1'b0, cap_if.ad_data_i} <= hyst_lo_s);
  end

  // Re-arm tracking: any crossing disarms, a far-side sample arms.
  always_comb begin
    armed_d = armed_q;
    if (cap_if.arm_i) begin
      armed_d = 1'b0;
    end else if (wr_en_s) begin
      if (qualify_s) begin
        armed_d = 1'b1;
      end else if (cross_s) begin
        armed_d = 1'b0;
      end else begin
        armed_d = armed_q;
      end
    end else begin
      armed_d = armed_q;
    end
  end

  // A crossing only counts once the signal has been re-armed.
  always_comb begin
    trig_s = cross_s && armed_q;
  end

  // Hysteresis arm flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end
`else
  // Plain threshold crossing triggers directly.
  always_comb begin
    trig_s = cross_s;
  end
`endif

  // Next-state, pointer and counter logic; arm overrides every state.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    level_d     = level_q;
    edge_d      = edge_q;
    prev_d      = prev_q;
    trig_addr_d = trig_addr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    wr_en_s     = 1'b0;
    rd_acc_s    = 1'b0;

    if (cap_if.pretrig_i > PRE_MAX) begin
      pre_clamp_s = PRE_MAX;
    end else begin
      pre_clamp_s = cap_if.pretrig_i;
    end
    pre_last_s  = {1'b0, pre_q} - ONE_C;
    post_last_s = DEPTH_C - {1'b0, pre_q} - ONE_C;

    if (cap_if.arm_i) begin
      pre_d    = pre_clamp_s;
      level_d  = cap_if.trig_level_i;
      edge_d   = cap_if.trig_edge_i;
      // The arm-cycle sample is the reference for the first compared sample.
      prev_d   = cap_if.ad_data_i;
      wr_ptr_d = '0;
      cnt_d    = '0;
      rd_cnt_d = '0;
      if (pre_clamp_s == '0) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_PRE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_PRE: begin
          wr_en_s = 1'b1;
          if (cnt_q == pre_last_s) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d   = cnt_q + ONE_C;
            state_d = S_PRE;
          end
        end
        S_WAIT: begin
          wr_en_s = 1'b1;
          if (trig_s || cap_if.force_i) begin
            trig_addr_d = wr_ptr_q;
            // The trigger sample is the first of the post-trigger samples.
            cnt_d       = ONE_C;
            state_d     = S_POST;
          end else begin
            state_d     = S_WAIT;
          end
        end
        S_POST: begin
          wr_en_s = 1'b1;
          if (cnt_q == post_last_s) begin
            rd_ptr_d = trig_addr_q - pre_q;
            rd_cnt_d = '0;
            state_d  = S_DONE;
          end else begin
            cnt_d    = cnt_q + ONE_C;
            state_d  = S_POST;
          end
        end
        S_DONE: begin
          if (cap_if.rd_en_i) begin
            rd_acc_s = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_IDX) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        prev_d   = cap_if.ad_data_i;
      end else begin
        wr_ptr_d = wr_ptr_d;
        prev_d   = prev_d;
      end
    end
  end

  // Control/state registers and registered status decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      level_q     <= 10'd0;
      edge_q      <= 1'b0;
      prev_q      <= 10'd0;
      trig_addr_q <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      level_q     <= level_d;
      edge_q      <= edge_d;
      prev_q      <= prev_d;
      trig_addr_q <= trig_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_acc_s;
      busy_q      <= (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Buffer write port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_q] <= cap_if.ad_data_i;
    end
  end

  // Buffer read port: data lands one clock after an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 10'd0;
    end else if (rd_acc_s) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign cap_if.rd_data_o  = rd_data_q;
  assign cap_if.rd_valid_o = rd_valid_q;
  assign cap_if.busy_o     = busy_q;
  assign cap_if.done_o     = done_q;

endmodule
